// File: rtl/riscv_pkg.sv
// Shared encodings and the stage-control payload for the 5-stage RISC-V core.
// Contents: ResultSrc encodings, forward-select encodings, ctrl_t struct,
// default register-address width.
package riscv_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned RES_W      = 2;
    localparam int unsigned FWD_W      = 2;
    localparam int unsigned ALU_W      = 3;

    // Writeback result source
    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

    // ALU operand forward select
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    // Decode controls carried down the pipe (register fields travel separately)
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [RES_W-1:0] result_src;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic [ALU_W-1:0] alu_control;
        logic             alu_src;
    } ctrl_t;

endpackage

// File: rtl/hazard_pipe_ctrl_if.sv
// Control bus between the datapath and hazard_pipe_ctrl.
// master: datapath side (drives ID decode + ZeroE, receives pipeline controls).
// slave : hazard_pipe_ctrl side.
interface hazard_pipe_ctrl_if
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = 32
);
    logic              ValidD;
    logic              RegWriteD;
    logic              MemWriteD;
    logic              JumpD;
    logic              BranchD;
    logic              ALUSrcD;
    logic [RES_W-1:0]  ResultSrcD;
    logic [ALU_W-1:0]  ALUControlD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              ZeroE;

    logic [ALU_W-1:0]  ALUControlE;
    logic              ALUSrcE;
    logic              MemWriteM;
    logic [RES_W-1:0]  ResultSrcW;
    logic              RegWriteW;
    logic [REG_AW-1:0] RdW;
    logic              PCSrcE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [FWD_W-1:0]  ForwardAE;
    logic [FWD_W-1:0]  ForwardBE;
    logic [CNT_W-1:0]  InstRet;

    modport master (
        output ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
        input  ALUControlE, ALUSrcE, MemWriteM, ResultSrcW, RegWriteW, RdW,
               PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               InstRet
    );

    modport slave (
        input  ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
        output ALUControlE, ALUSrcE, MemWriteM, ResultSrcW, RegWriteW, RdW,
               PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               InstRet
    );

endinterface

// File: rtl/hazard_pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational RAW hazard and forward-select logic.
// Inputs : D-stage source registers, E/M/W writer info, E-stage sources.
// Outputs: raw_stall, fwd_a, fwd_b.
// Build option HAZARD_PIPE_FWD_EN: forwarding on, only load-use stalls.
// Without it, forward selects are 00 and any E/M writer match stalls.
module hazard_detect
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              reg_write_e,
    input  logic [RES_W-1:0]  result_src_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    output logic              raw_stall,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b
);

    // A writer of a nonzero rd that a D-stage source reads (x0 never matches)
    function automatic logic dep_d(input logic we, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
        return we && (rd != '0) && ((rd == a) || (rd == b));
    endfunction

`ifdef HAZARD_PIPE_FWD_EN
    // MEM result beats WB result when both write the same register
    function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                                 input logic we_m, input logic [REG_AW-1:0] rdm,
                                                 input logic we_w, input logic [REG_AW-1:0] rdw);
        if (we_m && (rdm != '0) && (rdm == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rdw != '0) && (rdw == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        raw_stall = dep_d(reg_write_e, rd_e, rs1_d, rs2_d) && (result_src_e == RES_MEM);
        fwd_a     = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
        fwd_b     = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    end
`else
    logic unused_fwd;

    // No bypass: wait until the writer reaches WB (same-cycle RF write/read)
    always_comb begin
        raw_stall = dep_d(reg_write_e, rd_e, rs1_d, rs2_d) ||
                    dep_d(reg_write_m, rd_m, rs1_d, rs2_d);
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
    end

    assign unused_fwd = ^{result_src_e, rs1_e, rs2_e, reg_write_w, rd_w};
`endif

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: ID/EX, EX/MEM, MEM/WB control registers, hazard stall/flush,
// forwarding selects and retired-instruction counter.
// Ports: CLK, RST (async active-low), bus (hazard_pipe_ctrl_if.slave).
// Build option HAZARD_PIPE_FWD_EN selects forwarding (see hazard_detect).
module hazard_pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               CLK,
    input  logic               RST,
    hazard_pipe_ctrl_if.slave  bus
);

    ctrl_t             d_ctrl;
    ctrl_t             e_ctrl;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic              m_valid, m_reg_write, m_mem_write;
    logic [RES_W-1:0]  m_result_src;
    logic [REG_AW-1:0] rd_m;
    logic              w_valid, w_reg_write;
    logic [RES_W-1:0]  w_result_src;
    logic [REG_AW-1:0] rd_w;
    logic [CNT_W-1:0]  inst_ret;
    logic              raw_stall;
    logic              pcsrc_c;
    logic              flush_e_c;
    logic [FWD_W-1:0]  fwd_a, fwd_b;

    // Pack the ID-stage decode
    always_comb begin
        d_ctrl             = '0;
        d_ctrl.valid       = bus.ValidD;
        d_ctrl.reg_write   = bus.RegWriteD;
        d_ctrl.result_src  = bus.ResultSrcD;
        d_ctrl.mem_write   = bus.MemWriteD;
        d_ctrl.jump        = bus.JumpD;
        d_ctrl.branch      = bus.BranchD;
        d_ctrl.alu_control = bus.ALUControlD;
        d_ctrl.alu_src     = bus.ALUSrcD;
    end

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .rs1_d        (bus.Rs1D),
        .rs2_d        (bus.Rs2D),
        .reg_write_e  (e_ctrl.reg_write),
        .result_src_e (e_ctrl.result_src),
        .rd_e         (rd_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .reg_write_m  (m_reg_write),
        .rd_m         (rd_m),
        .reg_write_w  (w_reg_write),
        .rd_w         (rd_w),
        .raw_stall    (raw_stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    assign pcsrc_c   = (e_ctrl.branch & bus.ZeroE) | e_ctrl.jump;
    assign flush_e_c = raw_stall | pcsrc_c;

    // ID/EX: a flush loads a full bubble
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_ctrl <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
        end else if (flush_e_c) begin
            e_ctrl <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
        end else begin
            e_ctrl <= d_ctrl;
            rs1_e  <= bus.Rs1D;
            rs2_e  <= bus.Rs2D;
            rd_e   <= bus.RdD;
        end
    end

    // EX/MEM and MEM/WB always advance; retire count follows WB valid
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_valid      <= 1'b0;
            m_reg_write  <= 1'b0;
            m_result_src <= '0;
            m_mem_write  <= 1'b0;
            rd_m         <= '0;
            w_valid      <= 1'b0;
            w_reg_write  <= 1'b0;
            w_result_src <= '0;
            rd_w         <= '0;
            inst_ret     <= '0;
        end else begin
            m_valid      <= e_ctrl.valid;
            m_reg_write  <= e_ctrl.reg_write;
            m_result_src <= e_ctrl.result_src;
            m_mem_write  <= e_ctrl.mem_write;
            rd_m         <= rd_e;
            w_valid      <= m_valid;
            w_reg_write  <= m_reg_write;
            w_result_src <= m_result_src;
            rd_w         <= rd_m;
            if (w_valid) begin
                inst_ret <= inst_ret + CNT_W'(1);
            end
        end
    end

    assign bus.ALUControlE = e_ctrl.alu_control;
    assign bus.ALUSrcE     = e_ctrl.alu_src;
    assign bus.MemWriteM   = m_mem_write;
    assign bus.ResultSrcW  = w_result_src;
    assign bus.RegWriteW   = w_reg_write;
    assign bus.RdW         = rd_w;
    assign bus.PCSrcE      = pcsrc_c;
    // A taken branch/jump overrides the stall so the target PC is kept
    assign bus.StallF      = raw_stall & ~pcsrc_c;
    assign bus.StallD      = raw_stall & ~pcsrc_c;
    assign bus.FlushD      = pcsrc_c;
    assign bus.FlushE      = flush_e_c;
    assign bus.ForwardAE   = fwd_a;
    assign bus.ForwardBE   = fwd_b;
    assign bus.InstRet     = inst_ret;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed hazard scenarios plus random
// instruction streams checked every cycle against an instruction-level model.
module tb_hazard_pipe_ctrl;
    import riscv_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    hazard_pipe_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    hazard_pipe_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct packed {
        logic          v;
        logic          rw;
        logic [1:0]    res;
        logic          mw;
        logic          j;
        logic          br;
        logic [2:0]    alu;
        logic          src;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
    } ins_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: instruction held in each stage, retired count
    ins_t        st_e, st_m, st_w, cur_d;
    logic [31:0] m_cnt;
    ins_t        prog[$];

    int obs_stall, obs_flush_d, obs_fa_wb, obs_fwd_any, obs_both_mem;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic ins_t alu_op(input int rd, input int rs1, input int rs2);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rw = 1'b1; i.res = RES_ALU;
        i.rd = AW'(rd); i.rs1 = AW'(rs1); i.rs2 = AW'(rs2);
        return i;
    endfunction

    function automatic ins_t load_op(input int rd, input int rs1);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rw = 1'b1; i.res = RES_MEM; i.src = 1'b1;
        i.rd = AW'(rd); i.rs1 = AW'(rs1);
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i = '0;
        if ($urandom_range(7) == 0) return i;
        i.v   = 1'b1;
        i.rw  = 1'($urandom_range(1));
        i.mw  = 1'($urandom_range(1));
        i.br  = ($urandom_range(7) == 0);
        i.j   = ($urandom_range(15) == 0);
        case ($urandom_range(2))
            0:       i.res = RES_ALU;
            1:       i.res = RES_MEM;
            default: i.res = RES_PC4;
        endcase
        i.alu = 3'($urandom_range(7));
        i.src = 1'($urandom_range(1));
        i.rs1 = AW'($urandom_range(3));
        i.rs2 = AW'($urandom_range(3));
        i.rd  = AW'($urandom_range(3));
        return i;
    endfunction

    function automatic ins_t fetch();
        if (prog.size() == 0) return '0;
        return prog.pop_front();
    endfunction

    // Instruction s writes a nonzero register that d reads
    function automatic logic reads_result(input ins_t s, input ins_t d);
        return s.rw && (s.rd != 0) && ((s.rd == d.rs1) || (s.rd == d.rs2));
    endfunction

    function automatic logic [1:0] fwd_of(input logic [AW-1:0] rs);
        if (st_m.rw && st_m.rd != 0 && st_m.rd == rs) return FWD_MEM;
        if (st_w.rw && st_w.rd != 0 && st_w.rd == rs) return FWD_WB;
        return FWD_RF;
    endfunction

    task automatic model_reset();
        st_e = '0; st_m = '0; st_w = '0; m_cnt = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_alu_control_e"}, 32'(bus.ALUControlE), 0);
        check_eq({tag, "_alu_src_e"},     32'(bus.ALUSrcE), 0);
        check_eq({tag, "_mem_write_m"},   32'(bus.MemWriteM), 0);
        check_eq({tag, "_result_src_w"},  32'(bus.ResultSrcW), 0);
        check_eq({tag, "_reg_write_w"},   32'(bus.RegWriteW), 0);
        check_eq({tag, "_rd_w"},          32'(bus.RdW), 0);
        check_eq({tag, "_pcsrc_e"},       32'(bus.PCSrcE), 0);
        check_eq({tag, "_stall_f"},       32'(bus.StallF), 0);
        check_eq({tag, "_stall_d"},       32'(bus.StallD), 0);
        check_eq({tag, "_flush_d"},       32'(bus.FlushD), 0);
        check_eq({tag, "_flush_e"},       32'(bus.FlushE), 0);
        check_eq({tag, "_fwd_a"},         32'(bus.ForwardAE), 0);
        check_eq({tag, "_fwd_b"},         32'(bus.ForwardBE), 0);
        check_eq({tag, "_inst_ret"},      bus.InstRet, 0);
    endtask

    // Present cur_d, check every output, clock once and advance the model
    task automatic run_cycle(input logic zero);
        logic pc, raw, st, fd, fe;
        logic [1:0] fa, fb;
        bus.ValidD      = cur_d.v;
        bus.RegWriteD   = cur_d.rw;
        bus.MemWriteD   = cur_d.mw;
        bus.JumpD       = cur_d.j;
        bus.BranchD     = cur_d.br;
        bus.ALUSrcD     = cur_d.src;
        bus.ResultSrcD  = cur_d.res;
        bus.ALUControlD = cur_d.alu;
        bus.Rs1D        = cur_d.rs1;
        bus.Rs2D        = cur_d.rs2;
        bus.RdD         = cur_d.rd;
        bus.ZeroE       = zero;
        #1;
        pc = (st_e.br && zero) || st_e.j;
`ifdef HAZARD_PIPE_FWD_EN
        raw = reads_result(st_e, cur_d) && (st_e.res == RES_MEM);
        fa  = fwd_of(st_e.rs1);
        fb  = fwd_of(st_e.rs2);
`else
        raw = reads_result(st_e, cur_d) || reads_result(st_m, cur_d);
        fa  = FWD_RF;
        fb  = FWD_RF;
`endif
        st = raw && !pc;
        fd = pc;
        fe = raw || pc;
        check_eq("alu_control_e", 32'(bus.ALUControlE), 32'(st_e.alu));
        check_eq("alu_src_e",     32'(bus.ALUSrcE),     32'(st_e.src));
        check_eq("mem_write_m",   32'(bus.MemWriteM),   32'(st_m.mw));
        check_eq("result_src_w",  32'(bus.ResultSrcW),  32'(st_w.res));
        check_eq("reg_write_w",   32'(bus.RegWriteW),   32'(st_w.rw));
        check_eq("rd_w",          32'(bus.RdW),         32'(st_w.rd));
        check_eq("pcsrc_e",       32'(bus.PCSrcE),      32'(pc));
        check_eq("stall_f",       32'(bus.StallF),      32'(st));
        check_eq("stall_d",       32'(bus.StallD),      32'(st));
        check_eq("flush_d",       32'(bus.FlushD),      32'(fd));
        check_eq("flush_e",       32'(bus.FlushE),      32'(fe));
        check_eq("fwd_a",         32'(bus.ForwardAE),   32'(fa));
        check_eq("fwd_b",         32'(bus.ForwardBE),   32'(fb));
        check_eq("inst_ret",      bus.InstRet,          m_cnt);
        obs_stall    += int'(bus.StallD);
        obs_flush_d  += int'(bus.FlushD);
        obs_fa_wb    += int'(bus.ForwardAE == FWD_WB);
        obs_fwd_any  += int'(bus.ForwardAE != FWD_RF || bus.ForwardBE != FWD_RF);
        obs_both_mem += int'(bus.ForwardAE == FWD_MEM && bus.ForwardBE == FWD_MEM);
        @(posedge CLK);
        if (st_w.v) m_cnt = m_cnt + 32'd1;
        st_w = st_m;
        st_m = st_e;
        st_e = fe ? '0 : cur_d;
        if (!st) begin
            if (fd) begin
                cur_d = '0;
                cur_d = fetch();  // the IF slot is squashed too
                cur_d = '0;
            end else begin
                cur_d = fetch();
            end
        end
        @(negedge CLK);
    endtask

    task automatic clear_obs();
        obs_stall = 0; obs_flush_d = 0; obs_fa_wb = 0; obs_fwd_any = 0; obs_both_mem = 0;
    endtask

    // Run the queued program to completion and empty the pipe
    task automatic drain(input logic zero);
        int guard;
        guard = 0;
        while ((prog.size() != 0 || cur_d.v) && guard < 500) begin
            run_cycle(zero);
            guard++;
        end
        if (guard >= 500) check_eq("drain_timeout", 32'(guard), 0);
        repeat (4) run_cycle(zero);
    endtask

    localparam bit FWD =
`ifdef HAZARD_PIPE_FWD_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        logic [31:0] ret0;
        RST = 1'b0;
        cur_d = '0;
        model_reset();
        clear_obs();
        bus.ZeroE = 1'b0;
        bus.ValidD = 1'b0; bus.RegWriteD = 1'b0; bus.MemWriteD = 1'b0;
        bus.JumpD = 1'b0; bus.BranchD = 1'b0; bus.ALUSrcD = 1'b0;
        bus.ResultSrcD = '0; bus.ALUControlD = '0;
        bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
        repeat (2) @(negedge CLK);
        #1;
        check_all_zero("por");
        @(negedge CLK);
        RST = 1'b1;

        // Load-use: lw x5 ; add x6,x5,x1
        clear_obs();
        prog.push_back(load_op(5, 1));
        prog.push_back(alu_op(6, 5, 1));
        drain(1'b1);
        check_eq("loaduse_stalls", 32'(obs_stall), FWD ? 32'd1 : 32'd2);
        check_eq("loaduse_fwd_wb", 32'(obs_fa_wb), FWD ? 32'd1 : 32'd0);

        // MEM beats WB: add x7 ; add x7 ; sub x8,x7,x7
        clear_obs();
        prog.push_back(alu_op(7, 1, 1));
        prog.push_back(alu_op(7, 2, 2));
        prog.push_back(alu_op(8, 7, 7));
        drain(1'b1);
        check_eq("prio_both_mem", 32'(obs_both_mem), FWD ? 32'd1 : 32'd0);
        check_eq("prio_stalls",   32'(obs_stall),    FWD ? 32'd0 : 32'd2);

        // x0 writer never forwards or stalls
        clear_obs();
        prog.push_back(alu_op(0, 1, 2));
        prog.push_back(alu_op(1, 0, 0));
        drain(1'b1);
        check_eq("x0_stalls", 32'(obs_stall),   0);
        check_eq("x0_fwd",    32'(obs_fwd_any), 0);

        // Taken branch that also carries a load-use match on D
        begin
            ins_t b;
            b = load_op(5, 1);
            b.br = 1'b1;
            clear_obs();
            ret0 = bus.InstRet;
            prog.push_back(b);
            prog.push_back(alu_op(6, 5, 1));
            prog.push_back(alu_op(9, 1, 1));
            prog.push_back(alu_op(10, 1, 1));
            drain(1'b1);
            check_eq("br_stalls",  32'(obs_stall),   0);
            check_eq("br_flush_d", 32'(obs_flush_d), 1);
            check_eq("br_retired", bus.InstRet - ret0, 2);
        end

        // Back-to-back dependency: add x3 ; add x4,x3,x3
        clear_obs();
        prog.push_back(alu_op(3, 1, 2));
        prog.push_back(alu_op(4, 3, 3));
        drain(1'b1);
        check_eq("b2b_stalls", 32'(obs_stall),   FWD ? 32'd0 : 32'd2);
        check_eq("b2b_fwd",    32'(obs_fwd_any), FWD ? 32'd1 : 32'd0);

        // Random streams with random ZeroE
        for (int n = 0; n < 600; n++) prog.push_back(rand_ins());
        while (prog.size() > 100) run_cycle(1'($urandom_range(1)));

        // Reset mid-stream with work in flight
        cur_d = prog.pop_front();
        bus.Rs1D = 5'd1; bus.Rs2D = 5'd2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst_async");
        @(posedge CLK);
        @(negedge CLK);
        check_all_zero("rst_held");
        prog.delete();
        RST = 1'b1;
        prog.push_back(alu_op(1, 0, 0));
        prog.push_back(alu_op(2, 0, 0));
        prog.push_back(alu_op(3, 0, 0));
        prog.push_back(alu_op(4, 0, 0));
        cur_d = fetch();
        repeat (6) run_cycle(1'b0);
        check_eq("post_rst_ret3", bus.InstRet, 3);
        run_cycle(1'b0);
        check_eq("post_rst_ret4", bus.InstRet, 4);
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_ctrl.md
# hazard_pipe_ctrl

Registered pipeline-control block for the 5-stage RISC-V core. It takes the ID-stage decode outputs from the control unit and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It detects RAW and control hazards and drives the stall, flush and forwarding selects into the datapath. It also keeps a retired-instruction counter.

## Interface
- Parameters:
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 32: retired-instruction counter width.
- Ports:
- `CLK` in 1: core clock. All state updates on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `ValidD` in 1: the ID stage holds a real instruction (0 = bubble).
- `RegWriteD`, `MemWriteD`, `JumpD`, `BranchD`, `ALUSrcD` in 1 each: ID-stage decode.
- `ResultSrcD` in 2: 00 ALU, 01 load data, 10 PC+4.
- `ALUControlD` in 3: ALU operation.
- `Rs1D`, `Rs2D`, `RdD` in REG_AW: ID-stage register fields.
- `ZeroE` in 1: ALU zero flag in EX.
- `ALUControlE` out 3, `ALUSrcE` out 1: EX-stage controls.
- `MemWriteM` out 1: MEM-stage store enable.
- `ResultSrcW` out 2, `RegWriteW` out 1, `RdW` out REG_AW: WB-stage controls.
- `PCSrcE` out 1: take the branch/jump target.
- `StallF`, `StallD` out 1: hold the PC and the IF/ID register.
- `FlushD`, `FlushE` out 1: clear the IF/ID register and insert a bubble in ID/EX.
- `ForwardAE`, `ForwardBE` out 2: 00 register file, 01 WB result, 10 MEM ALU result.
- `InstRet` out CNT_W: count of retired instructions.

## Operation
- The stage registers E, M and W each hold `Valid`, RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, Rs1, Rs2 and Rd. Only the fields each stage needs are kept.
- E register on each clock edge:
  - When `FlushE`=1, every field loads 0. This is a bubble: Valid=0, RegWrite=0, MemWrite=0, Rd=0.
  - Otherwise it loads the D-stage inputs.
- M loads from E and W loads from M on every edge. Neither is ever stalled or flushed.
- `PCSrcE` = (BranchE & ZeroE) | JumpE. This is combinational from the E register and `ZeroE`.
- Register x0 never causes a hazard. Any match with Rd=0 is ignored.
- Load-use condition: `ResultSrcE`=01 & RegWriteE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- `raw_stall` is the hazard condition for the current configuration (see Configuration).
- `StallF` = `StallD` = raw_stall & ~PCSrcE. A taken branch or jump in EX overrides the stall, so the target PC is never lost.
- `FlushD` = PCSrcE.
- `FlushE` = raw_stall | PCSrcE.
- Forwarding for A (B is identical, using Rs2E):
  - 10 when RegWriteM & RdM≠0 & RdM==Rs1E.
  - else 01 when RegWriteW & RdW≠0 & RdW==Rs1E.
  - else 00.
  - MEM always has priority over WB.
- The register file writes in the first half-cycle. A D-stage read that matches the W stage therefore needs neither a stall nor forwarding.
- `InstRet` increments by 1 on each edge where ValidW=1. It wraps modulo 2^CNT_W.

## Timing
- Reset (RST=0, asynchronous) clears all stage registers and `InstRet` to 0.
- As a result, every output reads 0 during reset. `StallF`, `StallD`, `FlushD` and `FlushE` are 0 because the stage registers are empty.
- Release of reset is synchronous to `CLK`.
- Reset asserted mid-operation discards all in-flight control. The first instruction after release retires on the 4th edge after it is presented at D.
- Stage latency: D→E 1 cycle, E→M 1 cycle, M→W 1 cycle.
- Stall and flush outputs are combinational in the same cycle as the hazard.
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 bubbles: the D slot and the E slot.
- When `PCSrcE`=1 and raw_stall=1 in the same cycle, the flush wins: no stall, and both D and E are flushed.

## Configuration
- Macro: `HAZARD_PIPE_FWD_EN`.
- Defined:
  - Forwarding is active.
  - raw_stall = the load-use condition only.
- Undefined:
  - `ForwardAE` and `ForwardBE` are tied to 00.
  - raw_stall = (RegWriteE & RdE≠0 & RdE∈{Rs1D,Rs2D}) | (RegWriteM & RdM≠0 & RdM∈{Rs1D,Rs2D}).
  - A dependent back-to-back pair costs 2 bubbles.

## Structure
- Shared package `riscv_pkg`:
  - ResultSrc encodings (RES_ALU=00, RES_MEM=01, RES_PC4=10).
  - Forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
  - Stage-control struct typedef.
  - REG_AW default.
- One sub-module, `hazard_detect`: purely combinational; produces raw_stall and the forward selects from the stage registers.
- The stage registers and the counter live in the top level.

## Test plan
- Reset: hold RST=0 mid-stream → all outputs 0 and `InstRet`=0. Release, then issue 4 valid ALU ops → `InstRet`=4 three edges after the last one.
- Load-use: `lw x5` followed by `add x6,x5,x1` → one cycle with `StallF`=`StallD`=`FlushE`=1, then `ForwardAE`=01 for the add in EX.
- MEM priority: `add x7`, `add x7`, `sub x8,x7,x7` → `ForwardAE`=`ForwardBE`=10, not 01.
- x0 writer: `add x0,…` followed by `add x1,x0,x0` → forward selects 00, no stall.
- Taken branch: beq in EX with ZeroE=1 → `PCSrcE`=`FlushD`=`FlushE`=1 and `StallF`=0, including when a load-use match exists on the same cycle. The two flushed instructions never increment `InstRet`.
- Without the macro: `add x3` followed by `add x4,x3,x3` → 2 stall cycles, forward selects 00 throughout.
